pipe_mdu_ctrl: RTL and testbench



---
 rtl/pipe_mdu_pkg.sv | 27 ++
 rtl/pipe_mdu_step.sv | 45 ++++
 rtl/pipe_mdu_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipe_mdu_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mdu_pkg
// Description : Shared types and constants for the iterative mul/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

  localparam logic MDU_MUL = 1'b0;
  localparam logic MDU_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } mdu_state_e;

  // Iteration counter width; never narrower than one bit.
  function automatic int mdu_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_mdu_step.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mdu_step
// Description : One combinational iteration of the unsigned magnitude datapath.
//               mul: MSB-first shift-add (Horner), so the multiplicand never
//                    has to move; only the low WIDTH bits are kept.
//               div: restoring step on remainder:quotient.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_mdu_step
  import pipe_mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH-1:0] acc,      // mul accumulator / div remainder
  input  logic [WIDTH-1:0] opnd,     // mul multiplicand / div divisor
  input  logic [WIDTH-1:0] shr,      // mul multiplier / div dividend->quotient
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] shr_nxt
);

  // The extra bit holds the borrow of the trial subtraction.
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] trial;

  // Single iteration of either algorithm, selected by op.
  always_comb begin
    acc_nxt   = acc;
    shr_nxt   = shr;
    rem_shift = '0;
    trial     = '0;
    if (op == MDU_MUL) begin
      acc_nxt = {acc[WIDTH-2:0], 1'b0} + (shr[WIDTH-1] ? opnd : '0);
      shr_nxt = {shr[WIDTH-2:0], 1'b0};
    end else begin
      rem_shift = {acc, shr[WIDTH-1]};
      trial     = rem_shift - {1'b0, opnd};
      shr_nxt   = {shr[WIDTH-2:0], ~trial[WIDTH]};
      acc_nxt   = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mdu_ctrl
// Description : Sequencer for the iterative signed mul/div unit. Accepts one
//               request from EX, stalls the pipe while busy, and returns the
//               result with its destination register as a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_mdu_ctrl
  import pipe_mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int RN_W  = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [RN_W-1:0]  rdn,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [RN_W-1:0]  wrn,
  output logic             dz
);

  localparam int CNT_W = mdu_cnt_w(WIDTH);

  mdu_state_e       state_q,  state_d;
  logic             op_q,     op_d;
  logic             sign_q,   sign_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] opnd_q,   opnd_d;
  logic [WIDTH-1:0] shr_q,    shr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [RN_W-1:0]  rdn_q,    rdn_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [RN_W-1:0]  wrn_q,    wrn_d;
  logic             done_q,   done_d;
  logic             dz_q,     dz_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_shr;

  // INT_MIN negates to itself, which is its correct unsigned magnitude.
  assign a_mag = a[WIDTH-1] ? (-a) : a;
  assign b_mag = b[WIDTH-1] ? (-b) : b;
  assign mag   = (op_q == MDU_DIV) ? shr_q : acc_q;

  pipe_mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op      (op_q),
    .acc     (acc_q),
    .opnd    (opnd_q),
    .shr     (shr_q),
    .acc_nxt (step_acc),
    .shr_nxt (step_shr)
  );

  // Next-state and datapath-load logic for IDLE -> CALC -> SIGN.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    shr_d    = shr_q;
    cnt_d    = cnt_q;
    rdn_d    = rdn_q;
    result_d = result_q;
    wrn_d    = wrn_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          rdn_d  = rdn;
          sign_d = a[WIDTH-1] ^ b[WIDTH-1];
          dz_d   = 1'b0;
          cnt_d  = CNT_W'(WIDTH - 1);
          acc_d  = '0;
          if (op == MDU_DIV) begin
            opnd_d = b_mag;
            shr_d  = a_mag;
          end else begin
            opnd_d = a_mag;
            shr_d  = b_mag;
          end
          // Division by zero skips the iterations entirely.
          if ((op == MDU_DIV) && (b == '0)) begin
            dz_d    = 1'b1;
            state_d = SIGN;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        shr_d = step_shr;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        done_d   = 1'b1;
        wrn_d    = rdn_q;
        result_d = dz_q ? '1 : (sign_q ? (-mag) : mag);
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and output registers; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      shr_q    <= '0;
      cnt_q    <= '0;
      rdn_q    <= '0;
      result_q <= '0;
      wrn_q    <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      shr_q    <= shr_d;
      cnt_q    <= cnt_d;
      rdn_q    <= rdn_d;
      result_q <= result_d;
      wrn_q    <= wrn_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign stall  = start & busy;
  assign done   = done_q;
  assign result = result_q;
  assign wrn    = wrn_q;
  assign dz     = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_mdu_ctrl
// Description : Directed self-checking bench for pipe_mdu_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_mdu_ctrl;

  localparam int WIDTH = 32;
  localparam int RN_W  = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             op    = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic [RN_W-1:0]  rdn   = '0;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [RN_W-1:0]  wrn;
  logic             dz;

  int total = 0;
  int bad   = 0;

  pipe_mdu_ctrl #(
    .WIDTH (WIDTH),
    .RN_W  (RN_W)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .rdn    (rdn),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result),
    .wrn    (wrn),
    .dz     (dz)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Present a request in cycle 0; returns at the falling edge of cycle 1.
  task automatic issue(input logic o, input logic [WIDTH-1:0] aa,
                       input logic [WIDTH-1:0] bb, input logic [RN_W-1:0] r);
    @(negedge clock);
    start = 1'b1; op = o; a = aa; b = bb; rdn = r;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Observation only: advance until done, noting the cycle and whether busy
  // stayed high before it. Returns at the falling edge of the done cycle.
  task automatic run_to_done(input int first_cyc, input int limit,
                             output int done_cyc, output bit busy_ok);
    done_cyc = -1;
    busy_ok  = 1'b1;
    for (int c = first_cyc; c <= limit; c++) begin
      if (done === 1'b1) begin
        done_cyc = c;
        return;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    @(negedge clock);
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (result !== '0)   begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    total++; if (wrn !== '0)      begin bad++; $display("FAIL reset_wrn got=%0d exp=0", wrn); end
    total++; if (dz !== 1'b0)     begin bad++; $display("FAIL reset_dz got=%b exp=0", dz); end
    total++; if (stall !== 1'b0)  begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    reset = 1'b0;
  endtask

  task automatic test_mul();
    int dc; bit bok;
    issue(1'b0, 32'd7, -32'sd3, 5'd9);
    run_to_done(1, 60, dc, bok);
    total++; if (dc != 34)             begin bad++; $display("FAIL mul_done_cycle got=%0d exp=34", dc); end
    total++; if (!bok)                 begin bad++; $display("FAIL mul_busy got=low exp=high before done"); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL mul_busy_at_done got=%b exp=0", busy); end
    total++; if (result !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_result got=%h exp=ffffffeb", result); end
    total++; if (wrn !== 5'd9)         begin bad++; $display("FAIL mul_wrn got=%0d exp=9", wrn); end
    total++; if (dz !== 1'b0)          begin bad++; $display("FAIL mul_dz got=%b exp=0", dz); end
    @(negedge clock);
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL mul_done_pulse got=%b exp=0", done); end
    total++; if (result !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_result_hold got=%h exp=ffffffeb", result); end
  endtask

  task automatic test_div();
    int dc; bit bok;
    issue(1'b1, -32'sd100, 32'd7, 5'd4);
    run_to_done(1, 60, dc, bok);
    total++; if (dc != 34 || !bok)     begin bad++; $display("FAIL div_timing got=%0d/%b exp=34/1", dc, bok); end
    total++; if (result !== 32'hFFFFFFF2) begin bad++; $display("FAIL div_result got=%h exp=fffffff2", result); end
    total++; if (wrn !== 5'd4)         begin bad++; $display("FAIL div_wrn got=%0d exp=4", wrn); end
    total++; if (dz !== 1'b0)          begin bad++; $display("FAIL div_dz got=%b exp=0", dz); end
  endtask

  task automatic test_signs();
    int dc; bit bok;
    // -6 * -7 = 42
    issue(1'b0, -32'sd6, -32'sd7, 5'd11);
    run_to_done(1, 60, dc, bok);
    total++; if (dc != 34 || result !== 32'd42) begin bad++; $display("FAIL mul_negneg got=%0d/%h exp=34/0000002a", dc, result); end
    // 100 / -7 = -14
    issue(1'b1, 32'd100, -32'sd7, 5'd12);
    run_to_done(1, 60, dc, bok);
    total++; if (dc != 34 || result !== 32'hFFFFFFF2) begin bad++; $display("FAIL div_posneg got=%0d/%h exp=34/fffffff2", dc, result); end
    // -100 / -7 = 14
    issue(1'b1, -32'sd100, -32'sd7, 5'd13);
    run_to_done(1, 60, dc, bok);
    total++; if (dc != 34 || result !== 32'd14) begin bad++; $display("FAIL div_negneg got=%0d/%h exp=34/0000000e", dc, result); end
  endtask

  task automatic test_div_zero();
    int dc; bit bok;
    issue(1'b1, 32'd5, 32'd0, 5'd2);
    total++; if (busy !== 1'b1)        begin bad++; $display("FAIL dz_busy_c1 got=%b exp=1", busy); end
    run_to_done(1, 10, dc, bok);
    total++; if (dc != 2)              begin bad++; $display("FAIL dz_done_cycle got=%0d exp=2", dc); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL dz_busy_at_done got=%b exp=0", busy); end
    total++; if (result !== 32'hFFFFFFFF) begin bad++; $display("FAIL dz_result got=%h exp=ffffffff", result); end
    total++; if (dz !== 1'b1)          begin bad++; $display("FAIL dz_flag got=%b exp=1", dz); end
    total++; if (wrn !== 5'd2)         begin bad++; $display("FAIL dz_wrn got=%0d exp=2", wrn); end
    @(negedge clock);
    total++; if (dz !== 1'b1)          begin bad++; $display("FAIL dz_sticky got=%b exp=1", dz); end
    issue(1'b0, 32'd2, 32'd3, 5'd7);
    total++; if (dz !== 1'b0)          begin bad++; $display("FAIL dz_clear got=%b exp=0", dz); end
    run_to_done(1, 60, dc, bok);
    total++; if (dc != 34 || result !== 32'd6) begin bad++; $display("FAIL dz_next_mul got=%0d/%h exp=34/00000006", dc, result); end
  endtask

  task automatic test_overflow();
    int dc; bit bok;
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd5);
    run_to_done(1, 60, dc, bok);
    total++; if (dc != 34)             begin bad++; $display("FAIL ovf_div_cycle got=%0d exp=34", dc); end
    total++; if (result !== 32'h80000000) begin bad++; $display("FAIL ovf_div_result got=%h exp=80000000", result); end
    total++; if (dz !== 1'b0)          begin bad++; $display("FAIL ovf_div_dz got=%b exp=0", dz); end
    issue(1'b0, 32'h00010000, 32'h00010000, 5'd6);
    run_to_done(1, 60, dc, bok);
    total++; if (dc != 34 || result !== 32'h0) begin bad++; $display("FAIL ovf_mul got=%0d/%h exp=34/00000000", dc, result); end
  endtask

  task automatic test_back_to_back();
    int dc; bit bok; bit stall_ok;
    @(negedge clock);
    start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4; rdn = 5'd1;
    @(negedge clock);
    // Second request is held on the inputs while the first runs.
    op = 1'b1; a = 32'd9; b = 32'd3; rdn = 5'd6;
    stall_ok = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      if (stall !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
      @(negedge clock);
    end
    total++; if (!stall_ok)            begin bad++; $display("FAIL b2b_stall got=low exp=high cycles 1..33"); end
    total++; if (done !== 1'b1)        begin bad++; $display("FAIL b2b_first_done got=%b exp=1", done); end
    total++; if (result !== 32'd12)    begin bad++; $display("FAIL b2b_first_result got=%h exp=0000000c", result); end
    total++; if (wrn !== 5'd1)         begin bad++; $display("FAIL b2b_first_wrn got=%0d exp=1", wrn); end
    total++; if (stall !== 1'b0)       begin bad++; $display("FAIL b2b_stall_drop got=%b exp=0", stall); end
    @(negedge clock);
    start = 1'b0;
    total++; if (busy !== 1'b1)        begin bad++; $display("FAIL b2b_second_accept got=%b exp=1", busy); end
    run_to_done(35, 100, dc, bok);
    total++; if (dc != 68 || !bok)     begin bad++; $display("FAIL b2b_second_cycle got=%0d/%b exp=68/1", dc, bok); end
    total++; if (result !== 32'd3)     begin bad++; $display("FAIL b2b_second_result got=%h exp=00000003", result); end
    total++; if (wrn !== 5'd6)         begin bad++; $display("FAIL b2b_second_wrn got=%0d exp=6", wrn); end
  endtask

  task automatic test_reset_abort();
    int dc; bit bok; bit seen;
    issue(1'b0, 32'd5, 32'd6, 5'd3);
    for (int c = 1; c < 10; c++) @(negedge clock);
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (result !== '0)        begin bad++; $display("FAIL abort_result got=%h exp=0", result); end
    total++; if (wrn !== '0)           begin bad++; $display("FAIL abort_wrn got=%0d exp=0", wrn); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    total++; if (seen)                 begin bad++; $display("FAIL abort_no_done got=activity exp=idle"); end
    issue(1'b0, 32'd6, 32'd7, 5'd12);
    run_to_done(1, 60, dc, bok);
    total++; if (dc != 34 || result !== 32'd42 || wrn !== 5'd12) begin
      bad++; $display("FAIL abort_restart got=%0d/%h/%0d exp=34/0000002a/12", dc, result, wrn);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_signs();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
